// File: rtl/spi_config_assembler_if.sv
// Bus between the SPI byte receiver / VGA timing side and the config assembler.
// The master drives the frame, sync and enable inputs; the slave returns config and status.
interface spi_config_assembler_if;
   logic        ena;
   logic        ss_n;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        vs;
   logic [31:0] config_out;
   logic        commit_pulse;
   logic        pending;
   logic [7:0]  status_byte;

   modport master (
      output ena, ss_n, byte_valid, byte_data, vs,
      input  config_out, commit_pulse, pending, status_byte
   );

   modport slave (
      input  ena, ss_n, byte_valid, byte_data, vs,
      output config_out, commit_pulse, pending, status_byte
   );
endinterface

// File: rtl/spi_config_assembler.sv
// Packs one SPI frame of bytes (MSB-first) into a staged word and commits it to
// config_out on the vsync assert edge, so the consumer never sees a torn update.
module spi_config_assembler #(
   parameter logic [31:0] RESET_CONFIG  = 32'h00FC_0000,
   parameter bit          VS_ACTIVE_LOW = 1'b1,
   parameter int unsigned FRAME_BYTES   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_config_assembler_if.slave bus
);

   localparam int unsigned W    = 8 * FRAME_BYTES;
   localparam logic [2:0]  FULL = 3'(FRAME_BYTES);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t       state, state_n;
   logic         ss_m, ss_s, ss_d;
   logic         vs_m, vs_s, vs_d;
   logic [W-1:0] shift, shift_n;
   logic [W-1:0] staged, staged_n;
   logic [2:0]   byte_cnt, cnt_n;
   logic         pending, pending_n;
   logic         err_short, err_short_n;
   logic         err_long, err_long_n;
   logic         overrun, overrun_n;
   logic [31:0]  config_r;
   logic         commit_r;
   logic         ss_fall, ss_rise, vs_assert, commit_go, frame_done;

   assign ss_fall   = ss_d & ~ss_s;
   assign ss_rise   = ~ss_d & ss_s;
   assign vs_assert = VS_ACTIVE_LOW ? (vs_d & ~vs_s) : (~vs_d & vs_s);
   assign commit_go = vs_assert & pending & bus.ena;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n     = state;
      shift_n     = shift;
      cnt_n       = byte_cnt;
      err_short_n = err_short;
      err_long_n  = err_long;
      overrun_n   = overrun;
      frame_done  = 1'b0;
      if (!bus.ena) begin
         state_n = IDLE;
         shift_n = '0;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state_n     = COLLECT;
                  shift_n     = '0;
                  cnt_n       = '0;
                  err_short_n = 1'b0;
                  err_long_n  = 1'b0;
                  overrun_n   = 1'b0;
               end
            end
            COLLECT: begin
               if (bus.byte_valid) begin
                  if (byte_cnt < FULL) begin
                     shift_n = {shift[W-9:0], bus.byte_data};
                     cnt_n   = byte_cnt + 3'd1;
                  end else begin
                     err_long_n = 1'b1;
                     state_n    = DRAIN;
                  end
               end
               // The byte arriving with ss_rise is counted before the frame is judged.
               if (ss_rise) begin
                  state_n = IDLE;
                  if (!err_long_n) begin
                     if (cnt_n == FULL) begin
                        frame_done = 1'b1;
                     end else begin
                        err_short_n = 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               if (ss_rise) begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      // A commit consuming the old word in the same cycle absorbs the new one cleanly.
      if (frame_done && pending && !commit_go) begin
         overrun_n = 1'b1;
      end
      staged_n  = frame_done ? shift_n : staged;
      pending_n = frame_done ? 1'b1 : (commit_go ? 1'b0 : pending);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ss_m      <= 1'b1;
         ss_s      <= 1'b1;
         ss_d      <= 1'b1;
         vs_m      <= VS_ACTIVE_LOW;
         vs_s      <= VS_ACTIVE_LOW;
         vs_d      <= VS_ACTIVE_LOW;
         shift     <= '0;
         staged    <= '0;
         byte_cnt  <= '0;
         pending   <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         overrun   <= 1'b0;
         config_r  <= RESET_CONFIG;
         commit_r  <= 1'b0;
      end else begin
         ss_m      <= bus.ss_n;
         ss_s      <= ss_m;
         ss_d      <= ss_s;
         vs_m      <= bus.vs;
         vs_s      <= vs_m;
         vs_d      <= vs_s;
         shift     <= shift_n;
         staged    <= staged_n;
         byte_cnt  <= cnt_n;
         pending   <= pending_n;
         err_short <= err_short_n;
         err_long  <= err_long_n;
         overrun   <= overrun_n;
         commit_r  <= commit_go;
         if (commit_go) begin
            config_r <= staged;
         end
      end
   end

   assign bus.config_out   = config_r;
   assign bus.commit_pulse = commit_r;
   assign bus.pending      = pending;
   assign bus.status_byte  = {pending, err_short, err_long, overrun, 1'b0, byte_cnt};

endmodule
